// File: rtl/instruction_executor.sv
// Instruction executor: accepts 21-bit instructions over valid/ready, drives the datapath
// control fields and runs global commands, including a word-serial multi-word nonce counter.
module instruction_executor #(
   parameter int NONCE_WORDS = 4,
   parameter int WORD_WIDTH  = 16
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [20:0]                       instruction_i,
   input  logic                              valid_i,
   output logic                              ready_o,
   output logic                              issue_o,
   output logic                              save_core_selection_o,
   output logic                              ram_write_o,
   output logic [7:0]                        address_o,
   output logic [1:0]                        input_select_o,
   output logic                              output_select_o,
   output logic                              output_enable_o,
   output logic [3:0]                        alu_opcode_o,
   output logic [NONCE_WORDS*WORD_WIDTH-1:0] nonce_o,
   output logic                              nonce_wrap_o,
   output logic                              done_o,
   output logic                              illegal_o
);

   localparam int                IDX_W    = (NONCE_WORDS > 1) ? $clog2(NONCE_WORDS) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NONCE_WORDS - 1);

   localparam logic [2:0] CMD_DATAPATH  = 3'd0;
   localparam logic [2:0] CMD_INC_NONCE = 3'd1;
   localparam logic [2:0] CMD_CLR_NONCE = 3'd2;

   typedef enum logic [1:0] {IDLE, EXEC, INC, DONE} state_t;

   state_t                 state_q;
   state_t                 state_d;
   logic [20:0]            instr_q;
   logic [IDX_W-1:0]       idx_q;
   logic [WORD_WIDTH-1:0]  word_q [NONCE_WORDS];
   logic                   wrap_q;

   logic                   accept;
   logic [WORD_WIDTH-1:0]  cur_word;
   logic                   word_ones;
   logic                   last_word;

   assign accept    = valid_i && (state_q == IDLE);
   assign cur_word  = word_q[idx_q];
   assign word_ones = &cur_word;
   assign last_word = (idx_q == LAST_IDX);

   // NOTE: state is updated with non-blocking assignments so every register sees
   // the pre-edge values of the others, regardless of process evaluation order.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      // NOTE: default assignment first, so no path through the case leaves state_d
      // unassigned and no latch is inferred.
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (valid_i) begin
               case (instruction_i[2:0])
                  CMD_DATAPATH:  state_d = EXEC;
                  CMD_INC_NONCE: state_d = INC;
                  default:       state_d = DONE;
               endcase
            end
         end
         EXEC:    state_d = DONE;
         // Carry ripples one word per cycle; stop as soon as a word did not overflow.
         INC:     if (!word_ones || last_word) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         instr_q <= '0;
         idx_q   <= '0;
         wrap_q  <= 1'b0;
         // NOTE: the nonce is a small register array, not a RAM, so every word is
         // reset; this is also what discards a partially carried increment.
         for (int i = 0; i < NONCE_WORDS; i++) word_q[i] <= '0;
      end else begin
         if (accept) instr_q <= instruction_i;

         if (accept && (instruction_i[2:0] == CMD_CLR_NONCE)) begin
            for (int i = 0; i < NONCE_WORDS; i++) word_q[i] <= '0;
            wrap_q <= 1'b0;
         end

         if (state_q == INC) begin
            word_q[idx_q] <= cur_word + WORD_WIDTH'(1);
            if (word_ones && !last_word) begin
               idx_q <= idx_q + IDX_W'(1);
            end else begin
               idx_q <= '0;
            end
            if (word_ones && last_word) wrap_q <= 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NONCE_WORDS; g++) begin : g_nonce
      assign nonce_o[g*WORD_WIDTH +: WORD_WIDTH] = word_q[g];
   end

   assign nonce_wrap_o = wrap_q;

   // Datapath fields are only driven during EXEC so the datapath never sees stale controls.
   always_comb begin
      ready_o   = 1'b0;
      issue_o   = 1'b0;
      done_o    = 1'b0;
      illegal_o = 1'b0;
      {save_core_selection_o, ram_write_o, address_o, input_select_o,
       output_select_o, output_enable_o, alu_opcode_o} = '0;
      case (state_q)
         IDLE: ready_o = 1'b1;
         EXEC: begin
            issue_o = 1'b1;
            {save_core_selection_o, ram_write_o, address_o, input_select_o,
             output_select_o, output_enable_o, alu_opcode_o} = instr_q[20:3];
         end
         DONE: begin
            done_o    = 1'b1;
            illegal_o = (instr_q[2:0] > CMD_CLR_NONCE);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_instruction_executor.sv
// Bench for instruction_executor: a default-width instance and a narrow-word instance run
// in lockstep so carry chains and the all-ones wrap are reachable in a few hundred increments.
module tb_instruction_executor;
   localparam int NW = 4;
   localparam int WB = 16;
   localparam int WS = 2;
   localparam logic [2:0] C_OP  = 3'd0;
   localparam logic [2:0] C_INC = 3'd1;
   localparam logic [2:0] C_CLR = 3'd2;

   logic clk = 1'b0;
   logic rst;
   logic valid;
   logic [20:0] instruction;

   logic rdy_b, iss_b, scs_b, rw_b, osel_b, oe_b, wrap_b, done_b, ill_b;
   logic [7:0] addr_b;
   logic [1:0] isel_b;
   logic [3:0] op_b;
   logic [NW*WB-1:0] nonce_b;
   logic [17:0] fld_b;

   logic rdy_s, iss_s, scs_s, rw_s, osel_s, oe_s, wrap_s, done_s, ill_s;
   logic [7:0] addr_s;
   logic [1:0] isel_s;
   logic [3:0] op_s;
   logic [NW*WS-1:0] nonce_s;
   logic [17:0] fld_s;

   assign fld_b = {scs_b, rw_b, addr_b, isel_b, osel_b, oe_b, op_b};
   assign fld_s = {scs_s, rw_s, addr_s, isel_s, osel_s, oe_s, op_s};

   int checks = 0;
   int failures = 0;

   // Reference model: the nonce is just an integer that counts modulo its width.
   logic [63:0] m_b;
   logic        m_wrap_b;
   logic [7:0]  m_s;
   logic        m_wrap_s;

   always #5 clk = ~clk;

   instruction_executor dut_b (
      .clk_i(clk), .rst_i(rst), .instruction_i(instruction), .valid_i(valid),
      .ready_o(rdy_b), .issue_o(iss_b), .save_core_selection_o(scs_b), .ram_write_o(rw_b),
      .address_o(addr_b), .input_select_o(isel_b), .output_select_o(osel_b),
      .output_enable_o(oe_b), .alu_opcode_o(op_b), .nonce_o(nonce_b),
      .nonce_wrap_o(wrap_b), .done_o(done_b), .illegal_o(ill_b)
   );

   instruction_executor #(.NONCE_WORDS(NW), .WORD_WIDTH(WS)) dut_s (
      .clk_i(clk), .rst_i(rst), .instruction_i(instruction), .valid_i(valid),
      .ready_o(rdy_s), .issue_o(iss_s), .save_core_selection_o(scs_s), .ram_write_o(rw_s),
      .address_o(addr_s), .input_select_o(isel_s), .output_select_o(osel_s),
      .output_enable_o(oe_s), .alu_opcode_o(op_s), .nonce_o(nonce_s),
      .nonce_wrap_o(wrap_s), .done_o(done_s), .illegal_o(ill_s)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // INC cycles = index of the highest word that changes when adding one, plus one.
   function automatic int inc_cycles(input logic [63:0] old_v, input logic [63:0] new_v,
                                     input int w);
      logic [63:0] diff;
      int k;
      diff = old_v ^ new_v;
      k = 1;
      for (int i = 1; i < NW; i++)
         if ((diff >> (i * w)) != 64'd0) k = i + 1;
      return k;
   endfunction

   // Handshake; returns #1 after the accept edge (cycle 1).
   task automatic accept(input logic [20:0] ins);
      int waited = 0;
      while (!(rdy_b && rdy_s) && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      check("ready_before_accept", {rdy_b, rdy_s}, 2'b11);
      instruction = ins;
      valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      instruction = 21'($urandom);
   endtask

   task automatic run(input logic [20:0] ins, input int pulse_at, input logic [20:0] pulse_ins,
                      output int db, output int ds);
      logic [2:0]  cmd;
      logic [63:0] nb;
      logic [7:0]  ns;
      logic        nwb, nws;
      int eb = 1, es = 1, last;
      int db_n = 0, ds_n = 0, ib_n = 0, is_n = 0, ib_at = 0, is_at = 0;
      int stray_b = 0, stray_s = 0, busy_b = 0, busy_s = 0;
      logic [17:0] fb = '0, fs = '0;
      logic illb = 1'b0, ills = 1'b0, rb_after = 1'b0, rs_after = 1'b0;
      db = 0;
      ds = 0;
      cmd = ins[2:0];
      nb = m_b; ns = m_s; nwb = m_wrap_b; nws = m_wrap_s;
      case (cmd)
         C_OP: begin eb = 2; es = 2; end
         C_INC: begin
            nb = m_b + 64'd1;
            ns = m_s + 8'd1;
            eb = inc_cycles(m_b, nb, WB) + 1;
            es = inc_cycles({56'd0, m_s}, {56'd0, ns}, WS) + 1;
            if (m_b == '1) nwb = 1'b1;
            if (m_s == '1) nws = 1'b1;
         end
         C_CLR: begin nb = '0; ns = '0; nwb = 1'b0; nws = 1'b0; end
         default: ;
      endcase

      accept(ins);
      last = ((eb > es) ? eb : es) + 2;
      for (int c = 1; c <= last; c++) begin
         if (c == pulse_at) begin
            instruction = pulse_ins;
            valid = 1'b1;
         end else begin
            valid = 1'b0;
         end
         if (done_b) begin db_n++; db = c; illb = ill_b; end else if (ill_b) stray_b++;
         if (done_s) begin ds_n++; ds = c; ills = ill_s; end else if (ill_s) stray_s++;
         if (iss_b) begin ib_n++; ib_at = c; fb = fld_b; end else if (fld_b != '0) stray_b++;
         if (iss_s) begin is_n++; is_at = c; fs = fld_s; end else if (fld_s != '0) stray_s++;
         if (c <= eb && rdy_b) busy_b++;
         if (c <= es && rdy_s) busy_s++;
         if (c == eb + 1) rb_after = rdy_b;
         if (c == es + 1) rs_after = rs_after | rdy_s;
         @(posedge clk); #1;
      end
      valid = 1'b0;

      check("done_cycle_b", db, eb);
      check("done_cycle_s", ds, es);
      check("done_count", {db_n[7:0], ds_n[7:0]}, 16'h0101);
      check("issue_count", {ib_n[7:0], is_n[7:0]}, (cmd == C_OP) ? 16'h0101 : 16'h0000);
      check("issue_cycle", {ib_at[7:0], is_at[7:0]}, (cmd == C_OP) ? 16'h0101 : 16'h0000);
      if (cmd == C_OP) begin
         check("fields_b", fb, ins[20:3]);
         check("fields_s", fs, ins[20:3]);
      end
      check("stray_outputs", {stray_b[7:0], stray_s[7:0]}, 16'h0);
      check("illegal_at_done", {illb, ills}, (cmd > C_CLR) ? 2'b11 : 2'b00);
      check("ready_while_busy", {busy_b[7:0], busy_s[7:0]}, 16'h0);
      check("ready_after_done", {rb_after, rs_after}, 2'b11);
      check("nonce_b", nonce_b, nb);
      check("nonce_s", {56'd0, nonce_s}, {56'd0, ns});
      check("wrap", {wrap_b, wrap_s}, {nwb, nws});
      m_b = nb; m_s = ns; m_wrap_b = nwb; m_wrap_s = nws;
   endtask

   // Called #1 after an edge; asserts reset mid-cycle and checks outputs before the next edge.
   task automatic reset_mid_cycle();
      #3 rst = 1'b1;
      #1;
      check("rst_ctl_b", {iss_b, done_b, ill_b, wrap_b, fld_b}, '0);
      check("rst_ctl_s", {iss_s, done_s, ill_s, wrap_s, fld_s}, '0);
      check("rst_nonce_b", nonce_b, '0);
      check("rst_nonce_s", {56'd0, nonce_s}, '0);
      @(posedge clk); #3 rst = 1'b0;
      @(posedge clk); #1;
      check("rst_ready", {rdy_b, rdy_s}, 2'b11);
      m_b = '0; m_s = '0; m_wrap_b = 1'b0; m_wrap_s = 1'b0;
   endtask

   typedef struct {
      logic [20:0] ins;
      int          done_b;
      int          done_s;
      logic [63:0] nonce_b;
      logic [7:0]  nonce_s;
      logic        wrap_s;
   } vec_t;

   vec_t tbl[10];

   initial begin
      int db, ds, n, r, pulse;
      logic [20:0] ins;

      rst = 1'b1;
      valid = 1'b0;
      instruction = '0;
      m_b = '0; m_s = '0; m_wrap_b = 1'b0; m_wrap_s = 1'b0;

      tbl[0] = '{{1'b0, 1'b0, 8'h5A, 2'b10, 1'b0, 1'b1, 4'hC, C_OP}, 2, 2, 64'd0, 8'h00, 1'b0};
      tbl[1] = '{{18'h2A5C3, C_INC}, 2, 2, 64'd1, 8'h01, 1'b0};
      tbl[2] = '{{18'h00000, C_INC}, 2, 2, 64'd2, 8'h02, 1'b0};
      tbl[3] = '{{18'h3FFFF, C_INC}, 2, 2, 64'd3, 8'h03, 1'b0};
      tbl[4] = '{{18'h00000, C_INC}, 2, 3, 64'd4, 8'h04, 1'b0};
      tbl[5] = '{{18'h3FFFF, 3'd5},  1, 1, 64'd4, 8'h04, 1'b0};
      tbl[6] = '{{18'h12345, C_CLR}, 1, 1, 64'd0, 8'h00, 1'b0};
      tbl[7] = '{{1'b1, 1'b1, 8'hFF, 2'b11, 1'b1, 1'b1, 4'hF, C_OP}, 2, 2, 64'd0, 8'h00, 1'b0};
      tbl[8] = '{{18'h00F0F, 3'd7},  1, 1, 64'd0, 8'h00, 1'b0};
      tbl[9] = '{{18'h00000, C_INC}, 2, 2, 64'd1, 8'h01, 1'b0};

      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk); #1;
      check("reset_ctl_b", {iss_b, done_b, ill_b, wrap_b, fld_b}, '0);
      check("reset_ctl_s", {iss_s, done_s, ill_s, wrap_s, fld_s}, '0);
      check("reset_nonce", nonce_b | {56'd0, nonce_s}, '0);
      check("reset_ready", {rdy_b, rdy_s}, 2'b11);

      for (int i = 0; i < 10; i++) begin
         run(tbl[i].ins, 0, '0, db, ds);
         check("tbl_done_b", db, tbl[i].done_b);
         check("tbl_done_s", ds, tbl[i].done_s);
         check("tbl_nonce_b", nonce_b, tbl[i].nonce_b);
         check("tbl_nonce_s", {56'd0, nonce_s}, {56'd0, tbl[i].nonce_s});
         check("tbl_wrap_s", wrap_s, tbl[i].wrap_s);
      end

      // Asynchronous reset while a datapath op is issuing.
      accept({1'b0, 1'b0, 8'h5A, 2'b10, 1'b0, 1'b1, 4'hC, C_OP});
      check("issue_before_rst", {iss_b, iss_s}, 2'b11);
      reset_mid_cycle();

      // Full wrap of the narrow nonce, sticky wrap flag, then clear.
      run({18'h0, C_CLR}, 0, '0, db, ds);
      repeat (255) run({18'h0, C_INC}, 0, '0, db, ds);
      check("all_ones_s", {56'd0, nonce_s}, 64'hFF);
      run({18'h0, C_INC}, 0, '0, db, ds);
      check("wrap_done_cycle", ds, 5);
      check("wrap_nonce_s", {56'd0, nonce_s}, 64'h0);
      check("wrap_flag", {wrap_b, wrap_s}, 2'b01);
      run({18'h0, C_INC}, 0, '0, db, ds);
      check("wrap_sticky", wrap_s, 1'b1);
      run({18'h0, C_CLR}, 0, '0, db, ds);
      check("clr_done_cycle", ds, 1);
      check("clr_wrap", wrap_s, 1'b0);

      // A clear pulsed on valid_i during a three-word carry must be ignored.
      repeat (15) run({18'h0, C_INC}, 0, '0, db, ds);
      run({18'h0, C_INC}, 1, {18'h0, C_CLR}, db, ds);
      check("busy_valid_done", ds, 4);
      check("busy_valid_nonce", {56'd0, nonce_s}, 64'h10);

      // Reset during the second INC cycle of a four-word carry.
      run({18'h0, C_CLR}, 0, '0, db, ds);
      repeat (63) run({18'h0, C_INC}, 0, '0, db, ds);
      accept({18'h0, C_INC});
      @(posedge clk); #1;
      check("carry_visible", {56'd0, nonce_s}, 64'h3C);
      check("not_done_mid_inc", done_s, 1'b0);
      reset_mid_cycle();
      n = 0;
      repeat (4) begin
         if (done_b || done_s) n++;
         @(posedge clk); #1;
      end
      check("no_done_after_rst", n, 0);

      // Randomized instruction stream against the model.
      repeat (400) begin
         r = $urandom_range(99);
         ins = 21'($urandom);
         if (r < 60)      ins[2:0] = C_INC;
         else if (r < 75) ins[2:0] = C_OP;
         else if (r < 77) ins[2:0] = C_CLR;
         else             ins[2:0] = 3'($urandom_range(7, 3));
         pulse = ($urandom_range(3) == 0) ? 1 : 0;
         run(ins, pulse, 21'($urandom), db, ds);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
